// File: rtl/enc_defines.sv
// Shared definitions for the CAVLC run-before path: drain states, bank depth, widths.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package enc_defines;

  localparam int BANKDEPTH = 16;
  localparam int RUNW      = 4;
  localparam int ZLW       = 4;
  localparam int CNTW      = 5;
  localparam int TZW       = 5;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RUN  = 2'd1,
    D_DONE = 2'd2
  } drain_st_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_ACT  = 1'b1
  } fill_st_t;

  // A run longer than the zeros still available is an upstream error: clamp to 0.
  function automatic logic [ZLW-1:0] zl_after(input logic [ZLW-1:0] zl,
                                              input logic [RUNW-1:0] run);
    return (run > zl) ? '0 : zl - run;
  endfunction

  function automatic logic [ZLW-1:0] zl_init(input logic [TZW-1:0] tz);
    return (tz > 5'd15) ? '1 : tz[ZLW-1:0];
  endfunction

  // The last coefficient never carries a run_before, and nothing is coded once zl hits 0.
  function automatic logic sym_due(input logic [CNTW-1:0] idx,
                                   input logic [CNTW-1:0] cnt,
                                   input logic [ZLW-1:0]  zl);
    return (({1'b0, idx} + 6'd1) < {1'b0, cnt}) && (zl != '0);
  endfunction

endpackage

// File: rtl/cavlc_run_bank_flag.sv
// Per-bank holding register: full flag, coefficient count and total_zeros of the stored block.
// Latency: set/clr take effect on the next clk edge.
// Backpressure: none; set has priority over clr.
module cavlc_run_bank_flag
  import enc_defines::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic            clr,
  input  logic [CNTW-1:0] set_count,
  input  logic [TZW-1:0]  set_tz,
  output logic            full,
  output logic [CNTW-1:0] count,
  output logic [TZW-1:0]  tz
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      count <= '0;
      tz    <= '0;
    end else if (set) begin
      full  <= 1'b1;
      count <= set_count;
      tz    <= set_tz;
    end else if (clr) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/cavlc_run_ctrl.sv
// Run-before buffer sequencer: fills two 16-entry banks, drains (run, zeros_left) pairs; CAVLC_RUN_PINGPONG_EN overlaps fill and drain.
// Latency: first rb_valid 2 cycles after block latch, then one symbol per cycle; blk_done 1 cycle after the last handshake.
// Backpressure: run_ready low while the write bank is full; rb_ready low holds rb_run/rb_zeros_left stable.
module cavlc_run_ctrl #(
  parameter int ADDRWIDTH = 5,
  parameter int DATAWIDTH = 4,
  parameter int BANKDEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_valid,
  output logic                 run_ready,
  input  logic [DATAWIDTH-1:0] run_data,
  input  logic                 run_last,
  input  logic [4:0]           blk_total_zeros,
  output logic [ADDRWIDTH-1:0] buf_waddr,
  output logic [DATAWIDTH-1:0] buf_wdata,
  output logic                 buf_we,
  output logic [ADDRWIDTH-1:0] buf_raddr,
  output logic                 buf_re,
  input  logic [DATAWIDTH-1:0] buf_rdata,
  output logic                 rb_valid,
  input  logic                 rb_ready,
  output logic [DATAWIDTH-1:0] rb_run,
  output logic [3:0]           rb_zeros_left,
  output logic                 blk_done,
  output logic                 err_ovf
);

  import enc_defines::*;

  localparam int IW = ADDRWIDTH - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BANKDEPTH - 1);
`ifdef CAVLC_RUN_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  fill_st_t        fill_st;
  logic            wbank;
  logic [IW-1:0]   wcnt;
  logic [IW-1:0]   widx;
  logic            push;
  logic            blk_latch;

  logic [1:0]      bank_full;
  logic [1:0]      bank_set;
  logic [1:0]      bank_clr;
  logic [CNTW-1:0] bank_cnt [2];
  logic [TZW-1:0]  bank_tz  [2];
  logic [CNTW-1:0] latch_cnt;

  drain_st_t       dstate;
  logic            rbank;
  logic [IW-1:0]   rp;
  logic [CNTW-1:0] idx;
  logic [CNTW-1:0] idx_nx;
  logic [CNTW-1:0] dcnt;
  logic [ZLW-1:0]  zl;
  logic [ZLW-1:0]  zl_nx;
  logic            hs;

  // ---------------- fill side ----------------
  assign run_ready = !bank_full[wbank];
  assign push      = run_valid && run_ready;
  assign blk_latch = push && (run_last || (wcnt == LAST_IDX));
  assign err_ovf   = push && !run_last && (wcnt == LAST_IDX);
  assign latch_cnt = {1'b0, wcnt} + 5'd1;

  always_comb begin
    widx = '0;
    if (fill_st == FILL_ACT) widx = wcnt;
  end

  assign buf_we    = push;
  assign buf_waddr = {wbank, widx};
  assign buf_wdata = push ? run_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_st <= FILL_IDLE;
      wcnt    <= '0;
      wbank   <= 1'b0;
    end else if (push) begin
      if (blk_latch) begin
        fill_st <= FILL_IDLE;
        wcnt    <= '0;
        wbank   <= PINGPONG ? ~wbank : 1'b0;
      end else begin
        fill_st <= FILL_ACT;
        wcnt    <= wcnt + 1'b1;
      end
    end
  end

  // Set comes from the fill side, clear from the drain side; both may fire in one cycle on different banks.
  assign bank_set[0] = blk_latch && (wbank == 1'b0);
  assign bank_set[1] = blk_latch && (wbank == 1'b1);
  assign bank_clr[0] = (dstate == D_DONE) && (rbank == 1'b0);
  assign bank_clr[1] = (dstate == D_DONE) && (rbank == 1'b1);

  cavlc_run_bank_flag u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .set       (bank_set[0]),
    .clr       (bank_clr[0]),
    .set_count (latch_cnt),
    .set_tz    (blk_total_zeros),
    .full      (bank_full[0]),
    .count     (bank_cnt[0]),
    .tz        (bank_tz[0])
  );

  cavlc_run_bank_flag u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .set       (bank_set[1]),
    .clr       (bank_clr[1]),
    .set_count (latch_cnt),
    .set_tz    (blk_total_zeros),
    .full      (bank_full[1]),
    .count     (bank_cnt[1]),
    .tz        (bank_tz[1])
  );

  // ---------------- drain side ----------------
  assign hs     = rb_valid && rb_ready;
  assign idx_nx = idx + 1'b1;
  assign zl_nx  = zl_after(zl, buf_rdata);

  // Look one entry ahead on a handshake so the registered RAM keeps up at one symbol per cycle.
  assign buf_raddr = {rbank, hs ? rp + 1'b1 : rp};
  assign buf_re    = (dstate == D_RUN);
  assign rb_run    = rb_valid ? buf_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate        <= D_IDLE;
      rbank         <= 1'b0;
      rp            <= '0;
      idx           <= '0;
      dcnt          <= '0;
      zl            <= '0;
      rb_valid      <= 1'b0;
      rb_zeros_left <= '0;
      blk_done      <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (dstate)
        D_IDLE: begin
          if (bank_full[rbank]) begin
            dstate <= D_RUN;
            rp     <= '0;
            idx    <= '0;
            dcnt   <= bank_cnt[rbank];
            zl     <= zl_init(bank_tz[rbank]);
          end
        end
        D_RUN: begin
          if (!rb_valid) begin
            if (sym_due(idx, dcnt, zl)) begin
              rb_valid      <= 1'b1;
              rb_zeros_left <= zl;
            end else begin
              dstate   <= D_DONE;
              blk_done <= 1'b1;
            end
          end else if (rb_ready) begin
            rp  <= rp + 1'b1;
            idx <= idx_nx;
            zl  <= zl_nx;
            if (sym_due(idx_nx, dcnt, zl_nx)) begin
              rb_zeros_left <= zl_nx;
            end else begin
              rb_valid      <= 1'b0;
              rb_zeros_left <= '0;
              dstate        <= D_DONE;
              blk_done      <= 1'b1;
            end
          end
        end
        D_DONE: begin
          dstate <= D_IDLE;
          rbank  <= PINGPONG ? ~rbank : 1'b0;
        end
        default: dstate <= D_IDLE;
      endcase
    end
  end

endmodule
